control_sequencer: RTL and testbench

- Hardwired control unit for the single-bus 32-bit datapath.
- Issues the per-cycle register in/out strobes, ALU operation strobes and the memory Read strobe.
- Sequences fetch, decode and execute of register-register ALU, multiply/divide, unary and HI/LO move instructions.
- Sits beside the datapath; takes back only IRVal and a memory-ready handshake.

---
 rtl/control_defs.sv | 59 +++++
 rtl/reg_decoder.sv | 12 +
 rtl/control_sequencer.sv | 146 ++++++++++++++
 tb/tb_control_sequencer.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/control_defs.sv
// Shared definitions for the hardwired control sequencer: opcodes, state encoding,
// instruction field positions and the ALU strobe decode.
package control_defs;

    localparam int OP_HI = 31;
    localparam int OP_LO = 27;
    localparam int RA_LO = 23;
    localparam int RB_LO = 19;
    localparam int RC_LO = 15;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHL  = 5'b01000;
    localparam logic [4:0] OP_ROR  = 5'b01001;
    localparam logic [4:0] OP_ROL  = 5'b01010;
    localparam logic [4:0] OP_MUL  = 5'b01110;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_NEG  = 5'b10000;
    localparam logic [4:0] OP_NOT  = 5'b10001;
    localparam logic [4:0] OP_MFHI = 5'b10111;
    localparam logic [4:0] OP_MFLO = 5'b11000;
    localparam logic [4:0] OP_NOP  = 5'b11001;
    localparam logic [4:0] OP_HALT = 5'b11010;

    typedef enum logic [2:0] {
        S_FETCH0, S_FETCH1, S_FETCH2, S_T3, S_T4, S_T5, S_T6, S_HALT
    } state_e;

    // Bit positions inside the ALU strobe vector
    localparam int ALU_SIGS = 13;
    localparam int A_ADD = 0,  A_SUB = 1,  A_MUL = 2,  A_DIV = 3,  A_SHR = 4;
    localparam int A_SHL = 5,  A_ROR = 6,  A_ROL = 7,  A_AND = 8,  A_OR  = 9;
    localparam int A_NEG = 10, A_NOT = 11, A_INCPC = 12;

    function automatic logic [ALU_SIGS-1:0] alu_strobe(input logic [4:0] op);
        logic [ALU_SIGS-1:0] s;
        s = '0;
        case (op)
            OP_ADD: s[A_ADD] = 1'b1;
            OP_SUB: s[A_SUB] = 1'b1;
            OP_AND: s[A_AND] = 1'b1;
            OP_OR:  s[A_OR]  = 1'b1;
            OP_SHR: s[A_SHR] = 1'b1;
            OP_SHL: s[A_SHL] = 1'b1;
            OP_ROR: s[A_ROR] = 1'b1;
            OP_ROL: s[A_ROL] = 1'b1;
            OP_MUL: s[A_MUL] = 1'b1;
            OP_DIV: s[A_DIV] = 1'b1;
            OP_NEG: s[A_NEG] = 1'b1;
            OP_NOT: s[A_NOT] = 1'b1;
            default: ;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/reg_decoder.sv
// 4-bit register index to one-hot select, gated by an enable.
module reg_decoder #(
    parameter int N = 16
) (
    input  logic [3:0]   idx_i,
    input  logic         en_i,
    output logic [N-1:0] sel_o
);
    for (genvar i = 0; i < N; i++) begin : g_sel
        assign sel_o[i] = en_i && (idx_i == 4'(i));
    end
endmodule

// File: rtl/control_sequencer.sv
// Hardwired fetch/decode/execute sequencer for the single-bus datapath.
// All strobes are a combinational decode of the state register and IRVal.
module control_sequencer
    import control_defs::*;
#(
    parameter int BITS      = 32,
    parameter int REGISTERS = 16,
    parameter int SIG_COUNT = 13
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 run,
    input  logic                 mem_ready,
    input  logic [BITS-1:0]      IRVal,
    output logic PCin, IRin, RYin, RZin, MARin, HIin, LOin, MDRin, Read,
    output logic MDRout, LOout, HIout, RZHIout, RZLOout, PCout,
    output logic ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, AND, OR, NEGATE, NOT, IncPC,
    output logic [REGISTERS-1:0] GPRin,
    output logic [REGISTERS-1:0] GPRout,
    output logic                 halted,
    output logic                 illegal
);
    state_e state_q, state_d;
    logic   wait_q, wait_d;
    logic   [SIG_COUNT-1:0] alu_sel;
    logic   gin_en, gout_en;
    logic   [3:0] gout_idx;
    logic   [4:0] op;
    logic   is_alu3, is_md, is_un;
    logic   unused_bits;

    assign op          = IRVal[OP_HI:OP_LO];
    assign unused_bits = ^IRVal[RC_LO-1:0];
    assign is_alu3     = (op >= OP_ADD) && (op <= OP_ROL);
    assign is_md       = (op == OP_MUL) || (op == OP_DIV);
    assign is_un       = (op == OP_NEG) || (op == OP_NOT);
    assign halted      = (state_q == S_HALT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH0;
            wait_q  <= 1'b0;
        end else if (run) begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        wait_d   = 1'b0;
        {PCin, IRin, RYin, RZin, MARin, HIin, LOin, MDRin, Read} = '0;
        {MDRout, LOout, HIout, RZHIout, RZLOout, PCout} = '0;
        alu_sel  = '0;
        gin_en   = 1'b0;
        gout_en  = 1'b0;
        gout_idx = IRVal[RB_LO +: 4];
        illegal  = 1'b0;
        // reset is checked here too so strobes die the instant it rises
        if (run && !reset) begin
            case (state_q)
                S_FETCH0: begin
                    {PCout, MARin, RZin} = 3'b111;
                    alu_sel[A_INCPC] = 1'b1;
                    state_d = S_FETCH1;
                end
                S_FETCH1: begin
                    {RZLOout, Read, MDRin} = 3'b111;
                    // PC loads only on the first FETCH1 cycle of a stall
                    PCin   = !wait_q;
                    wait_d = !mem_ready;
                    if (mem_ready) state_d = S_FETCH2;
                end
                S_FETCH2: begin
                    {MDRout, IRin} = 2'b11;
                    state_d = S_T3;
                end
                S_T3: begin
                    state_d = S_FETCH0;
                    if (is_alu3 || is_md) begin
                        gout_en = 1'b1;
                        RYin    = 1'b1;
                        state_d = S_T4;
                    end else if (is_un) begin
                        gout_en = 1'b1;
                        alu_sel = alu_strobe(op);
                        RZin    = 1'b1;
                        state_d = S_T4;
                    end else if (op == OP_MFHI) begin
                        HIout  = 1'b1;
                        gin_en = 1'b1;
                    end else if (op == OP_MFLO) begin
                        LOout  = 1'b1;
                        gin_en = 1'b1;
                    end else if (op == OP_HALT) begin
                        state_d = S_HALT;
                    end else if (op != OP_NOP) begin
                        illegal = 1'b1;
                    end
                end
                S_T4: begin
                    state_d = S_FETCH0;
                    if (is_alu3 || is_md) begin
                        gout_idx = IRVal[RC_LO +: 4];
                        gout_en  = 1'b1;
                        alu_sel  = alu_strobe(op);
                        RZin     = 1'b1;
                        state_d  = S_T5;
                    end else begin
                        RZLOout = 1'b1;
                        gin_en  = 1'b1;
                    end
                end
                S_T5: begin
                    RZLOout = 1'b1;
                    state_d = S_FETCH0;
                    if (is_md) begin
                        LOin    = 1'b1;
                        state_d = S_T6;
                    end else begin
                        gin_en = 1'b1;
                    end
                end
                S_T6: begin
                    {RZHIout, HIin} = 2'b11;
                    state_d = S_FETCH0;
                end
                default: state_d = S_HALT;
            endcase
        end
    end

    assign {IncPC, NOT, NEGATE, OR, AND, ROL, ROR, SHL, SHR, DIV, MUL, SUB, ADD} = alu_sel;

    reg_decoder #(.N(REGISTERS)) u_gin (
        .idx_i (IRVal[RA_LO +: 4]),
        .en_i  (gin_en),
        .sel_o (GPRin)
    );

    reg_decoder #(.N(REGISTERS)) u_gout (
        .idx_i (gout_idx),
        .en_i  (gout_en),
        .sel_o (GPRout)
    );
endmodule

// File: tb/tb_control_sequencer.sv
// Randomized bench: each instruction is expanded into its expected per-cycle
// strobe list and compared cycle by cycle against the sequencer.
module tb_control_sequencer;
    typedef logic [61:0] vec_t;

    localparam int B_ILL = 0, B_HLT = 1, B_GOUT = 2, B_GIN = 18, B_INCPC = 34;
    localparam int B_NOT = 35, B_NEG = 36, B_OR = 37, B_AND = 38, B_ROL = 39;
    localparam int B_ROR = 40, B_SHL = 41, B_SHR = 42, B_DIV = 43, B_MUL = 44;
    localparam int B_SUB = 45, B_ADD = 46, B_PCOUT = 47, B_RZLO = 48, B_RZHI = 49;
    localparam int B_HIOUT = 50, B_LOOUT = 51, B_MDROUT = 52, B_READ = 53, B_MDRIN = 54;
    localparam int B_LOIN = 55, B_HIIN = 56, B_MARIN = 57, B_RZIN = 58, B_RYIN = 59;
    localparam int B_IRIN = 60, B_PCIN = 61;

    logic clk = 1'b0, reset = 1'b1, run = 1'b0, mem_ready = 1'b0;
    logic [31:0] IRVal = '0;
    logic PCin, IRin, RYin, RZin, MARin, HIin, LOin, MDRin, Read;
    logic MDRout, LOout, HIout, RZHIout, RZLOout, PCout;
    logic ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, AND, OR, NEGATE, NOT, IncPC;
    logic [15:0] GPRin, GPRout;
    logic halted, illegal;
    vec_t obs;

    int n_vec = 0, n_err = 0;
    vec_t exp_q[$];

    always #5 clk = ~clk;

    control_sequencer dut (
        .clk(clk), .reset(reset), .run(run), .mem_ready(mem_ready), .IRVal(IRVal),
        .PCin(PCin), .IRin(IRin), .RYin(RYin), .RZin(RZin), .MARin(MARin),
        .HIin(HIin), .LOin(LOin), .MDRin(MDRin), .Read(Read),
        .MDRout(MDRout), .LOout(LOout), .HIout(HIout), .RZHIout(RZHIout),
        .RZLOout(RZLOout), .PCout(PCout),
        .ADD(ADD), .SUB(SUB), .MUL(MUL), .DIV(DIV), .SHR(SHR), .SHL(SHL),
        .ROR(ROR), .ROL(ROL), .AND(AND), .OR(OR), .NEGATE(NEGATE), .NOT(NOT),
        .IncPC(IncPC), .GPRin(GPRin), .GPRout(GPRout), .halted(halted), .illegal(illegal)
    );

    assign obs = {PCin, IRin, RYin, RZin, MARin, HIin, LOin, MDRin, Read,
                  MDRout, LOout, HIout, RZHIout, RZLOout, PCout,
                  ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, AND, OR, NEGATE, NOT, IncPC,
                  GPRin, GPRout, halted, illegal};

    function automatic vec_t m(input int b);
        return vec_t'(1) << b;
    endfunction

    task automatic chk(input string tag, input vec_t got, input vec_t exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic vec_t alu_of(input logic [4:0] op);
        case (op)
            5'd3:  return m(B_ADD);
            5'd4:  return m(B_SUB);
            5'd5:  return m(B_AND);
            5'd6:  return m(B_OR);
            5'd7:  return m(B_SHR);
            5'd8:  return m(B_SHL);
            5'd9:  return m(B_ROR);
            5'd10: return m(B_ROL);
            5'd14: return m(B_MUL);
            5'd15: return m(B_DIV);
            5'd16: return m(B_NEG);
            5'd17: return m(B_NOT);
            default: return '0;
        endcase
    endfunction

    // Expected cycle list for one instruction with w FETCH1 wait cycles
    task automatic build(input logic [4:0] op, input int ra, input int rb, input int rc, input int w);
        exp_q.delete();
        exp_q.push_back(m(B_PCOUT) | m(B_MARIN) | m(B_INCPC) | m(B_RZIN));
        exp_q.push_back(m(B_RZLO) | m(B_PCIN) | m(B_READ) | m(B_MDRIN));
        repeat (w) exp_q.push_back(m(B_RZLO) | m(B_READ) | m(B_MDRIN));
        exp_q.push_back(m(B_MDROUT) | m(B_IRIN));
        if (op >= 5'd3 && op <= 5'd10) begin
            exp_q.push_back(m(B_GOUT + rb) | m(B_RYIN));
            exp_q.push_back(m(B_GOUT + rc) | alu_of(op) | m(B_RZIN));
            exp_q.push_back(m(B_RZLO) | m(B_GIN + ra));
        end else if (op == 5'd14 || op == 5'd15) begin
            exp_q.push_back(m(B_GOUT + rb) | m(B_RYIN));
            exp_q.push_back(m(B_GOUT + rc) | alu_of(op) | m(B_RZIN));
            exp_q.push_back(m(B_RZLO) | m(B_LOIN));
            exp_q.push_back(m(B_RZHI) | m(B_HIIN));
        end else if (op == 5'd16 || op == 5'd17) begin
            exp_q.push_back(m(B_GOUT + rb) | alu_of(op) | m(B_RZIN));
            exp_q.push_back(m(B_RZLO) | m(B_GIN + ra));
        end else if (op == 5'd23) begin
            exp_q.push_back(m(B_HIOUT) | m(B_GIN + ra));
        end else if (op == 5'd24) begin
            exp_q.push_back(m(B_LOOUT) | m(B_GIN + ra));
        end else if (op == 5'd25 || op == 5'd26) begin
            exp_q.push_back('0);
        end else begin
            exp_q.push_back(m(B_ILL));
        end
    endtask

    // stall_at>=0 forces stall_n run=0 cycles at step stall_at; rnd enables random stalls;
    // rst_at>=0 asserts reset asynchronously during that step and abandons the instruction.
    task automatic run_instr(input logic [4:0] op, input int ra, input int rb, input int rc,
                             input int w, input int stall_at, input int stall_n,
                             input int rst_at, input bit rnd);
        int k = 0;
        int stalls = 0;
        bit st;
        logic [31:0] ir;
        ir = {op, 4'(ra), 4'(rb), 4'(rc), 15'($urandom)};
        build(op, ra, rb, rc, w);
        while (k < exp_q.size()) begin
            @(negedge clk);
            IRVal = ir;
            st = (k == stall_at && stalls < stall_n) || (rnd && $urandom_range(0, 9) == 0);
            if (k == stall_at && st) stalls++;
            if (k >= 1 && k <= w) mem_ready = 1'b0;
            else if (k == w + 1) mem_ready = 1'b1;
            else mem_ready = 1'($urandom);
            run = !st;
            #1;
            chk($sformatf("%s op%0d k%0d", st ? "stall" : "seq", op, k), obs, st ? vec_t'(0) : exp_q[k]);
            if (k == rst_at && !st) begin
                #2 reset = 1'b1;
                #1 chk("rst_async", obs, '0);
                @(posedge clk);
                #1 reset = 1'b0;
                return;
            end
            if (!st) k++;
        end
    endtask

    task automatic halt_phase();
        repeat (20) begin
            @(negedge clk);
            run = 1'($urandom);
            mem_ready = 1'($urandom);
            #1 chk("halted", obs, m(B_HLT));
        end
        #2 reset = 1'b1;
        #1 chk("halt_rst", obs, '0);
        @(posedge clk);
        #1 reset = 1'b0;
        run = 1'b1;
    endtask

    function automatic logic [4:0] rnd_op();
        logic [4:0] o;
        do o = 5'($urandom); while (o == 5'd26);
        return o;
    endfunction

    initial begin
        #3 chk("reset_run0", obs, '0);
        run = 1'b1;
        #1 chk("reset_run1", obs, '0);
        @(posedge clk);
        #1 reset = 1'b0;

        run_instr(5'd3, 3, 1, 2, 0, -1, 0, -1, 0);    // ADD
        run_instr(5'd14, 0, 4, 5, 0, -1, 0, -1, 0);   // MUL
        run_instr(5'd3, 6, 2, 9, 3, -1, 0, -1, 0);    // FETCH1 wait of 3
        run_instr(5'd17, 2, 11, 0, 0, -1, 0, -1, 0);  // NOT
        run_instr(5'd23, 7, 0, 0, 0, -1, 0, -1, 0);   // MFHI
        run_instr(5'd31, 1, 1, 1, 0, -1, 0, -1, 0);   // undefined
        run_instr(5'd4, 5, 15, 0, 0, 2, 3, -1, 0);    // SUB, run=0 in FETCH2
        run_instr(5'd4, 5, 15, 0, 0, -1, 0, 4, 0);    // SUB, reset during T4
        run_instr(5'd24, 15, 0, 0, 1, -1, 0, -1, 0);  // MFLO

        for (int i = 0; i < 150; i++)
            run_instr(rnd_op(), $urandom_range(0, 15), $urandom_range(0, 15),
                      $urandom_range(0, 15), ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0,
                      -1, 0, -1, 1);

        run_instr(5'd26, 0, 0, 0, 2, -1, 0, -1, 1);   // HALT
        halt_phase();
        for (int i = 0; i < 10; i++)
            run_instr(rnd_op(), $urandom_range(0, 15), $urandom_range(0, 15),
                      $urandom_range(0, 15), $urandom_range(0, 2), -1, 0, -1, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish, vectors %0d", n_vec);
        $fatal(1);
    end
endmodule
